// File: rtl/bram_fifo_reader.sv
// bram_fifo_reader
// Pulls words from a registered-output upstream FIFO (one cycle read latency)
// and presents them as a valid/ready stream. Output is fully registered:
// a 2-entry in-order skid buffer absorbs the read latency, so rd_en can be
// issued speculatively while still never overrunning the buffer.
// A burst counter marks every BURST_LEN-th word with m_last.
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   en               - read enable; low stops issuing new FIFO reads
//   fifo_empty       - upstream FIFO empty flag
//   fifo_data        - upstream read data, valid the cycle after rd_en
//   rd_en            - pop request to upstream FIFO
//   m_valid/m_ready  - output stream handshake
//   m_data, m_last   - output stream word and end-of-burst marker
module bram_fifo_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam logic [15:0] LAST_CNT = 16'(BURST_LEN - 1);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];

  logic                  pop;
  logic [1:0]            occ_after_pop;
  logic [2:0]            pending;

  // Read issue: a word may be requested only if the buffer will still have
  // room for it once every already-requested word has landed.
  always_comb begin
    pop           = (occ_q != 2'd0) && m_ready;
    occ_after_pop = occ_q - {1'b0, pop};
    pending       = {1'b0, occ_after_pop} + {2'b0, inflight_q};
    // rst_n gating keeps rd_en low throughout reset, not just after an edge.
    rd_en         = rst_n && en && !fifo_empty && (pending < 3'd2);
  end

  always_comb begin
    buf_d[0]   = buf_q[0];
    buf_d[1]   = buf_q[1];
    occ_d      = occ_after_pop + {1'b0, inflight_q};
    inflight_d = rd_en;
    cnt_d      = cnt_q;

    // Head always shifts forward on a pop; slot 1 becomes don't-care.
    if (pop) begin
      buf_d[0] = buf_q[1];
    end

    // Arriving word lands in the first free slot after the pop is applied.
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) begin
        buf_d[0] = fifo_data;
      end else begin
        buf_d[1] = fifo_data;
      end
    end

    if (pop) begin
      cnt_d = (cnt_q == LAST_CNT) ? 16'd0 : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        buf_q[gi] <= '0;
      end else begin
        buf_q[gi] <= buf_d[gi];
      end
    end
  end

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf_q[0];
  assign m_last  = m_valid && (cnt_q == LAST_CNT);

endmodule

// File: tb/tb_bram_fifo_reader.sv
module tb_bram_fifo_reader;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          m_ready;

  logic          rd_a, mv_a, ml_a;
  logic [DW-1:0] md_a;
  logic          rd_b, mv_b, ml_b;
  logic [DW-1:0] md_b;
  logic          rd_c, mv_c, ml_c;
  logic [DW-1:0] md_c;

  always #5 clk = ~clk;

  // Three builds driven by identical stimulus; only the burst length differs,
  // so rd_en and data behaviour are identical and only m_last diverges.
  bram_fifo_reader #(.DATA_WIDTH(DW), .BURST_LEN(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .rd_en(rd_a), .m_valid(mv_a), .m_ready(m_ready), .m_data(md_a), .m_last(ml_a));
  bram_fifo_reader #(.DATA_WIDTH(DW), .BURST_LEN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .rd_en(rd_b), .m_valid(mv_b), .m_ready(m_ready), .m_data(md_b), .m_last(ml_b));
  bram_fifo_reader #(.DATA_WIDTH(DW), .BURST_LEN(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .rd_en(rd_c), .m_valid(mv_c), .m_ready(m_ready), .m_data(md_c), .m_last(ml_c));

  logic [DW-1:0] q[$];
  logic          rd_s;
  int            total = 0;
  int            bad   = 0;

  typedef struct {
    logic          en;
    logic          rdy;
    logic          rd;
    logic          mv;
    logic [DW-1:0] d;
    logic          l16;
    logic          l3;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    rd_s = rd_a;
  endtask

  // Upstream FIFO model: word popped in cycle t appears on fifo_data in t+1.
  task automatic adv();
    @(posedge clk);
    #1;
    if (rd_s && q.size() > 0) fifo_data = q.pop_front();
    fifo_empty = (q.size() == 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    m_ready = 1'b0;
    q.delete();
    fifo_empty = 1'b1;
    fifo_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic preload(input int base, input int n);
    for (int i = 0; i < n; i++) q.push_back(DW'(base + i));
    fifo_empty = (q.size() == 0);
  endtask

  // 32 words with m_ready high: first valid 2 cycles after first rd_en.
  task automatic run_stream(input int base);
    preload(base, 32);
    en = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 36; c++) begin
      int k;
      logic emv;
      sample();
      k = c - 2;
      emv = (c >= 2) && (c <= 33);
      chk($sformatf("stream_rd c%0d", c), rd_a, (c <= 31));
      chk($sformatf("stream_mv c%0d", c), mv_a, emv);
      if (emv) chk($sformatf("stream_data c%0d", c), md_a, DW'(base + k));
      chk($sformatf("stream_last16 c%0d", c), ml_a, emv && (k % 16 == 15));
      chk($sformatf("stream_last3 c%0d", c), ml_c, emv && (k % 3 == 2));
      chk($sformatf("stream_last1 c%0d", c), ml_b, emv);
      adv();
    end
  endtask

  initial begin
    int rd_cnt, got, recv, c16, c3, cyc;
    logic [DW-1:0] exp_val, prev_d;
    logic prev_stall, prev_l;

    // en, rdy, rd, mv, data, last16, last3 -- m_ready held low with 5 words
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0,  1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0,  1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hA1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hA1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hA1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'hA1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'hA2, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'hA3, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hA4, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hA5, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0,  1'b0, 1'b0};

    // Reset state, with a non-empty FIFO and en high to prove rd_en is gated.
    rst_n = 1'b0;
    en = 1'b1;
    m_ready = 1'b1;
    fifo_data = 16'hFFFF;
    preload(16'h70, 3);
    #12;
    chk("reset_rd_en", rd_a, 0);
    chk("reset_m_valid", mv_a, 0);
    chk("reset_m_last", ml_a, 0);
    chk("reset_m_data", md_a, 0);
    do_reset();

    // Table: backpressure fills buffer with exactly 2 reads, then drains.
    preload(16'hA1, 5);
    for (int i = 0; i < 11; i++) begin
      en = tbl[i].en;
      m_ready = tbl[i].rdy;
      sample();
      chk($sformatf("tbl_rd r%0d", i), rd_a, tbl[i].rd);
      chk($sformatf("tbl_mv r%0d", i), mv_a, tbl[i].mv);
      if (tbl[i].mv) chk($sformatf("tbl_data r%0d", i), md_a, tbl[i].d);
      chk($sformatf("tbl_last16 r%0d", i), ml_a, tbl[i].l16);
      chk($sformatf("tbl_last3 r%0d", i), ml_c, tbl[i].l3);
      chk($sformatf("tbl_last1 r%0d", i), ml_b, tbl[i].mv);
      adv();
    end

    // Full-rate stream 0x01..0x20.
    do_reset();
    run_stream(1);

    // en dropped after 3 reads: exactly 3 words out, no further rd_en.
    do_reset();
    preload(16'h31, 10);
    m_ready = 1'b1;
    rd_cnt = 0;
    got = 0;
    for (int c = 0; c < 15; c++) begin
      en = (c < 3);
      sample();
      if (rd_s) rd_cnt++;
      if (mv_a && m_ready) begin
        chk($sformatf("endrop_data w%0d", got), md_a, DW'(16'h31 + got));
        got++;
      end
      adv();
    end
    chk("endrop_rd_count", rd_cnt, 3);
    chk("endrop_word_count", got, 3);
    en = 1'b1;
    sample();
    chk("endrop_resume_rd", rd_a, 1);
    adv();

    // Async reset mid-operation, then fresh data from cnt=0.
    do_reset();
    preload(16'h41, 5);
    en = 1'b1;
    m_ready = 1'b0;
    sample(); adv();
    sample(); adv();
    sample();
    chk("midrst_pre_mv", mv_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mv", mv_a, 0);
    chk("midrst_data", md_a, 0);
    chk("midrst_last", ml_a, 0);
    chk("midrst_rd", rd_a, 0);
    do_reset();
    run_stream(16'h51);

    // Random backpressure and random FIFO refill, scoreboard on order.
    do_reset();
    en = 1'b1;
    got = 0;
    recv = 0;
    c16 = 0;
    c3 = 0;
    exp_val = 16'h100;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    cyc = 0;
    while (recv < 1000 && cyc < 6000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (got < 1000 && $urandom_range(0, 3) != 0) begin
        q.push_back(DW'(16'h100 + got));
        got++;
      end
      fifo_empty = (q.size() == 0);
      sample();
      chk("rand_rd_while_empty", rd_s & fifo_empty, 0);
      if (prev_stall) begin
        chk("rand_stall_data", md_a, prev_d);
        chk("rand_stall_last", ml_a, prev_l);
      end
      if (mv_a && m_ready) begin
        chk($sformatf("rand_data w%0d", recv), md_a, exp_val);
        chk($sformatf("rand_last16 w%0d", recv), ml_a, (c16 == 15));
        chk($sformatf("rand_last3 w%0d", recv), ml_c, (c3 == 2));
        chk($sformatf("rand_last1 w%0d", recv), ml_b, 1);
        exp_val++;
        c16 = (c16 + 1) % 16;
        c3 = (c3 + 1) % 3;
        recv++;
      end
      prev_stall = mv_a && !m_ready;
      prev_d = md_a;
      prev_l = ml_a;
      adv();
      cyc++;
    end
    chk("rand_word_count", recv, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
